// File: rtl/sdram_pkg.sv
// sdram_pkg: shared state encodings, timing defaults and strobe levels
// for the SDRAM port arbiter.
package sdram_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_GAP = 2'd2} state_t;
   localparam int GAP_DEF = 8;
   localparam int TIMEOUT_DEF = 64;
   localparam logic STROBE_OFF = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker; the last-grant register starts at 1
// so port 0 wins the first contention.
module rr_arb2 (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant,
   output logic       any
);
   logic last;
   assign any = |req;
   assign grant = &req ? ~last : req[1];
   always_ff @(posedge CLK or negedge RST)
      if (!RST) last <= 1'b1;
      else if (update) last <= grant;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller command interface between
// the 68000 bus (port 0) and a DMA/video fetcher (port 1).
module sdram_port_arbiter
   import sdram_pkg::*;
#(
   parameter int GAP     = GAP_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = 7
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  REQ,
   input  logic [22:0] P0_A,
   input  logic [22:0] P1_A,
   input  logic [1:0]  P0_DS,
   input  logic [1:0]  P1_DS,
   input  logic [1:0]  P_RW,
   output logic [1:0]  ACK,
   output logic        ERR,
   output logic        OWN,
   output logic        SEL,
   output logic        MEM_AS,
   output logic        MEM_UDS,
   output logic        MEM_LDS,
   output logic        MEM_RW,
   output logic [22:0] MEM_A,
   input  logic        MEM_VALID,
   input  logic        MEM_INIT
);
   state_t state, state_nx;
   logic [TW-1:0] cnt, cnt_nx;
   logic as_nx, uds_nx, lds_nx, rw_nx, own_nx, sel_nx, err_nx, upd, gnt, any;
   logic [22:0] a_nx;
   logic [1:0] ack_nx;

   rr_arb2 u_arb (.CLK(CLK), .RST(RST), .req(REQ), .update(upd), .grant(gnt), .any(any));

   // Every output is computed here and registered below, so the strobes move
   // one edge after the decision that drives them.
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      as_nx = MEM_AS;
      uds_nx = MEM_UDS;
      lds_nx = MEM_LDS;
      rw_nx = MEM_RW;
      a_nx = MEM_A;
      own_nx = OWN;
      sel_nx = SEL;
      ack_nx = 2'b00;
      err_nx = 1'b0;
      upd = 1'b0;
      case (state)
         ST_IDLE:
            if (!MEM_INIT && any) begin
               upd = 1'b1;
               state_nx = ST_ACCESS;
               cnt_nx = '0;
               as_nx = 1'b0;
               {uds_nx, lds_nx} = gnt ? P1_DS : P0_DS;
               rw_nx = P_RW[gnt];
               a_nx = gnt ? P1_A : P0_A;
               own_nx = 1'b1;
               sel_nx = gnt;
            end
         ST_ACCESS: begin
            cnt_nx = cnt + 1'b1;
            // Completion wins over a coincident timeout, so ERR only when VALID is still high.
            if (!MEM_VALID || cnt == TW'(TIMEOUT - 1)) begin
               state_nx = ST_GAP;
               cnt_nx = '0;
               as_nx = STROBE_OFF;
               uds_nx = STROBE_OFF;
               lds_nx = STROBE_OFF;
               own_nx = 1'b0;
               ack_nx = SEL ? 2'b10 : 2'b01;
               err_nx = MEM_VALID;
            end
         end
         ST_GAP:
            if (cnt == TW'(GAP - 1)) state_nx = MEM_VALID ? ST_IDLE : ST_GAP;
            else cnt_nx = cnt + 1'b1;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state <= ST_IDLE;
         cnt <= '0;
         MEM_AS <= STROBE_OFF;
         MEM_UDS <= STROBE_OFF;
         MEM_LDS <= STROBE_OFF;
         MEM_RW <= 1'b1;
         MEM_A <= '0;
         OWN <= 1'b0;
         SEL <= 1'b0;
         ACK <= 2'b00;
         ERR <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         MEM_AS <= as_nx;
         MEM_UDS <= uds_nx;
         MEM_LDS <= lds_nx;
         MEM_RW <= rw_nx;
         MEM_A <= a_nx;
         OWN <= own_nx;
         SEL <= sel_nx;
         ACK <= ack_nx;
         ERR <= err_nx;
      end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed table of accesses plus hand sequences for
// init hold, contention, gap extension and asynchronous reset.
module tb_sdram_port_arbiter;
   logic        CLK = 1'b0, RST = 1'b0;
   logic [1:0]  REQ = 2'b00, P0_DS = 2'b11, P1_DS = 2'b11, P_RW = 2'b11;
   logic [22:0] P0_A = '0, P1_A = '0;
   logic        MEM_VALID = 1'b1, MEM_INIT = 1'b1;
   logic [1:0]  ACK;
   logic        ERR, OWN, SEL, MEM_AS, MEM_UDS, MEM_LDS, MEM_RW;
   logic [22:0] MEM_A;
   int n_cmp = 0, n_bad = 0;

   sdram_port_arbiter dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .P0_A(P0_A), .P1_A(P1_A), .P0_DS(P0_DS),
      .P1_DS(P1_DS), .P_RW(P_RW), .ACK(ACK), .ERR(ERR), .OWN(OWN), .SEL(SEL),
      .MEM_AS(MEM_AS), .MEM_UDS(MEM_UDS), .MEM_LDS(MEM_LDS), .MEM_RW(MEM_RW),
      .MEM_A(MEM_A), .MEM_VALID(MEM_VALID), .MEM_INIT(MEM_INIT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0] req; logic [22:0] a0, a1; logic [1:0] ds0, ds1, rw; int lat;
      logic sel; logic [22:0] ea; logic [1:0] eds; logic erw; logic [1:0] eack; logic eerr; int ek;
   } vec_t;
   vec_t v[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, n, na, hi;
      logic prev, bad;
      // lat = negedges after strobe-low before MEM_VALID low (255 = never); ek = negedges until ACK.
      v[0] = '{2'b01, 23'h123456, 23'h7ABCDE, 2'b00, 2'b11, 2'b01, 6,   1'b0, 23'h123456, 2'b00, 1'b1, 2'b01, 1'b0, 7};
      v[1] = '{2'b10, 23'h000001, 23'h2AAAAA, 2'b11, 2'b01, 2'b00, 3,   1'b1, 23'h2AAAAA, 2'b01, 1'b0, 2'b10, 1'b0, 4};
      v[2] = '{2'b11, 23'h555555, 23'h0F0F0F, 2'b10, 2'b01, 2'b10, 0,   1'b0, 23'h555555, 2'b10, 1'b0, 2'b01, 1'b0, 1};
      v[3] = '{2'b11, 23'h555555, 23'h0F0F0F, 2'b10, 2'b00, 2'b10, 63,  1'b1, 23'h0F0F0F, 2'b00, 1'b1, 2'b10, 1'b0, 64};
      v[4] = '{2'b10, 23'h3FFFFF, 23'h7FFFFF, 2'b00, 2'b11, 2'b11, 255, 1'b1, 23'h7FFFFF, 2'b11, 1'b1, 2'b10, 1'b1, 64};
      v[5] = '{2'b01, 23'h000000, 23'h7FFFFF, 2'b01, 2'b00, 2'b01, 62,  1'b0, 23'h000000, 2'b01, 1'b1, 2'b01, 1'b0, 63};
      v[6] = '{2'b11, 23'h111111, 23'h222222, 2'b00, 2'b10, 2'b01, 1,   1'b1, 23'h222222, 2'b10, 1'b0, 2'b10, 1'b0, 2};

      // Reset values
      repeat (2) @(negedge CLK);
      chk("rst_strobes", {MEM_AS, MEM_UDS, MEM_LDS, MEM_RW}, 4'hF);
      chk("rst_a", MEM_A, 0);
      chk("rst_ctl", {ACK, ERR, OWN, SEL}, 0);
      RST = 1'b1;

      // Init hold then first grant
      REQ = 2'b01; P0_A = 23'h0ABCDE; P0_DS = 2'b00; P_RW = 2'b11;
      bad = 1'b0;
      repeat (100) begin
         @(negedge CLK);
         if (MEM_AS !== 1'b1 || OWN !== 1'b0) bad = 1'b1;
      end
      chk("init_hold", bad, 0);
      MEM_INIT = 1'b0;
      @(negedge CLK);
      chk("init_as", MEM_AS, 0);
      chk("init_a", MEM_A, 23'h0ABCDE);
      MEM_VALID = 1'b0;
      @(negedge CLK);
      chk("init_ack", ACK, 2'b01);
      MEM_VALID = 1'b1; REQ = 2'b00;
      repeat (12) @(negedge CLK);

      // Table of single accesses
      foreach (v[i]) begin
         REQ = v[i].req; P0_A = v[i].a0; P1_A = v[i].a1;
         P0_DS = v[i].ds0; P1_DS = v[i].ds1; P_RW = v[i].rw;
         @(negedge CLK);
         chk($sformatf("v%0d_as", i), MEM_AS, 0);
         chk($sformatf("v%0d_own_sel", i), {OWN, SEL}, {1'b1, v[i].sel});
         chk($sformatf("v%0d_a", i), MEM_A, v[i].ea);
         chk($sformatf("v%0d_ds_rw", i), {MEM_UDS, MEM_LDS, MEM_RW}, {v[i].eds, v[i].erw});
         k = 0;
         while (ACK == 2'b00 && k < 80) begin
            if (k == v[i].lat) MEM_VALID = 1'b0;
            @(negedge CLK);
            k++;
         end
         chk($sformatf("v%0d_ack_cycle", i), k, v[i].ek);
         chk($sformatf("v%0d_ack_err", i), {ACK, ERR}, {v[i].eack, v[i].eerr});
         chk($sformatf("v%0d_release", i), {MEM_AS, MEM_UDS, MEM_LDS, OWN}, 4'b1110);
         MEM_VALID = 1'b1; REQ = 2'b00;
         @(negedge CLK);
         chk($sformatf("v%0d_ack_pulse", i), {ACK, ERR}, 0);
         repeat (12) @(negedge CLK);
      end

      // Contention: both ports held, 6-cycle controller
      REQ = 2'b11; P0_A = 23'h0AAAA0; P1_A = 23'h055550; P0_DS = 2'b00; P1_DS = 2'b00;
      n = 0; na = 0; k = 0; hi = 100; prev = 1'b1;
      for (int c = 0; c < 300 && na < 4; c++) begin
         @(negedge CLK);
         if (ACK != 2'b00) na++;
         if (MEM_AS === 1'b0 && prev === 1'b1) begin
            chk($sformatf("cont_sel%0d", n), SEL, n % 2);
            chk($sformatf("cont_a%0d", n), MEM_A, (n % 2) ? 23'h055550 : 23'h0AAAA0);
            if (n > 0) chk($sformatf("cont_gap%0d", n), hi >= 8, 1);
            n++;
            k = 0;
         end
         hi = MEM_AS ? hi + 1 : 0;
         prev = MEM_AS;
         if (!MEM_AS) begin
            if (k == 6) MEM_VALID = 1'b0;
            k++;
         end else MEM_VALID = 1'b1;
      end
      chk("cont_count", {n[7:0], na[7:0]}, 16'h0404);
      REQ = 2'b00; MEM_VALID = 1'b1;
      repeat (12) @(negedge CLK);

      // Gap extension: MEM_VALID held low after release
      REQ = 2'b01; P0_A = 23'h246802;
      @(negedge CLK);
      chk("gx_as", MEM_AS, 0);
      repeat (2) @(negedge CLK);
      MEM_VALID = 1'b0;
      @(negedge CLK);
      chk("gx_ack", ACK, 2'b01);
      bad = 1'b0;
      repeat (12) begin
         @(negedge CLK);
         if (MEM_AS !== 1'b1) bad = 1'b1;
      end
      chk("gx_no_early_as", bad, 0);
      MEM_VALID = 1'b1;
      @(negedge CLK);
      chk("gx_idle_as", MEM_AS, 1);
      @(negedge CLK);
      chk("gx_regrant", {MEM_AS, OWN}, 2'b01);
      MEM_VALID = 1'b0;
      @(negedge CLK);
      chk("gx_ack2", ACK, 2'b01);
      MEM_VALID = 1'b1; REQ = 2'b00;
      repeat (12) @(negedge CLK);

      // Async reset mid-access
      REQ = 2'b10; P1_DS = 2'b00;
      @(negedge CLK);
      chk("ar_as", {MEM_AS, MEM_UDS, MEM_LDS}, 0);
      repeat (3) @(negedge CLK);
      #2 RST = 1'b0;
      #1 chk("ar_release", {MEM_AS, MEM_UDS, MEM_LDS, OWN}, 4'b1110);
      REQ = 2'b00;
      @(negedge CLK);
      RST = 1'b1;
      MEM_VALID = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (c == 2) MEM_VALID = 1'b1;
         if (ACK !== 2'b00 || ERR !== 1'b0 || MEM_AS !== 1'b1) bad = 1'b1;
      end
      chk("ar_no_ack", bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command interface (AS/UDS/LDS/RW/A in; VALID/READY out) between two requesters: port 0 is the 68000 bus, port 1 is a DMA/video fetcher.
- Grants one access at a time with round-robin priority.
- Enforces a recovery gap so the controller's access-wait countdown completes before the next access.
- Aborts accesses that never complete (timeout).

Parameters:
- GAP, 8: idle cycles forced between strobe release and the next strobe assertion (covers the controller's 7-cycle access wait plus 1).
- TIMEOUT, 64: cycles in ACCESS without MEM_VALID low before abort.
- TW, 7: width of the timeout/gap counter; must satisfy 2^TW > max(GAP, TIMEOUT).

Ports:
- CLK  in  1  system clock (66 MHz); one clock domain. Already decided.
- RST  in  1  asynchronous, active-low reset. Already decided.
- REQ  in  2  per-port request, active high; the port holds ADDR/UDS/LDS/RW stable while REQ is high.
- P0_A  in  23  port 0 word address A[23:1].
- P1_A  in  23  port 1 word address A[23:1].
- P0_DS  in  2  port 0 {UDS,LDS}, active low.
- P1_DS  in  2  port 1 {UDS,LDS}, active low.
- P_RW  in  2  per-port RW (1 = read).
- ACK  out  2  per-port one-cycle completion pulse.
- ERR  out  1  one-cycle pulse alongside ACK when the access timed out.
- OWN  out  1  high while an access is in flight.
- SEL  out  1  port owning the access/data buffers; valid while OWN is high.
- MEM_AS  out  1  address strobe to the controller, active low.
- MEM_UDS  out  1  upper data strobe to the controller, active low.
- MEM_LDS  out  1  lower data strobe to the controller, active low.
- MEM_RW  out  1  RW to the controller.
- MEM_A  out  23  address to the controller.
- MEM_VALID  in  1  controller completion, active low: low = data valid / write taken.
- MEM_INIT  in  1  controller initialisation in progress, active high.

Behaviour:
- All outputs are registered.
- Reset values: MEM_AS=1, MEM_UDS=1, MEM_LDS=1, MEM_RW=1, MEM_A=0, ACK=00, ERR=0, OWN=0, SEL=0, state=IDLE, last-grant=1 (so port 0 wins the first contention), counter=0.
- Reset asserted mid-access drops the strobes immediately (asynchronously) and no ACK is issued.
- States: IDLE, ACCESS, GAP.
- IDLE:
  - MEM_INIT=1 → stay in IDLE, no grant.
  - Otherwise, when any REQ is high, pick the winner: the sole requester, or if both request, the port that is not last-grant.
  - On the same edge: latch the winner's A/DS/RW into MEM_*, set MEM_AS=0, set OWN=1, SEL=winner, last-grant=winner, counter=0, go to ACCESS.
  - Strobes are therefore low one cycle after REQ is sampled.
- ACCESS:
  - Increment counter each cycle.
  - MEM_VALID sampled low → next edge: ACK[SEL]=1 for exactly one cycle; MEM_AS, MEM_UDS and MEM_LDS go high; OWN=0; counter=0; go to GAP.
  - counter==TIMEOUT-1 with MEM_VALID still high → same release, plus ERR=1 with the ACK; go to GAP.
  - MEM_VALID low and timeout in the same cycle → normal completion; ERR=0.
  - REQ[SEL] dropping during ACCESS is a protocol violation. The access completes regardless and ACK still pulses.
  - Address and strobes are not re-sampled during ACCESS.
- GAP:
  - Strobes stay high.
  - Leave to IDLE only when counter==GAP-1 AND MEM_VALID is sampled high; otherwise keep counting, saturating at GAP-1.
  - Minimum strobe-high time is GAP cycles.
- Back-to-back: a port may keep REQ high after its ACK. It is re-arbitrated in IDLE, so with both ports requesting, grants alternate 0,1,0,1.
- MEM_INIT rising while in ACCESS or GAP: the in-flight access completes or times out normally, and no new grant is made until MEM_INIT=0.
- ACK is never high for both ports; ERR is never high without ACK.

Decomposition:
- Shared package (sdram_pkg), holding:
  - state encodings ST_IDLE=0, ST_ACCESS=1, ST_GAP=2;
  - the GAP and TIMEOUT defaults;
  - the active-low strobe idle constant STROBE_OFF=1.
- One natural sub-module, rr_arb2: a two-input round-robin picker with a last-grant register and an update enable. Its interface is req[1:0], update, grant, any.
- The address/strobe mux and the FSM remain in sdram_port_arbiter.

Test Plan:
- Init hold: MEM_INIT=1 with REQ=01 for 100 cycles → MEM_AS stays 1, OWN=0. Drop MEM_INIT → MEM_AS=0 one cycle after the next sampled REQ, with MEM_A=P0_A.
- Single read: REQ=01, P0_A=0x123456, P0_DS=00, RW=1, controller model asserts MEM_VALID low 6 cycles after MEM_AS low → ACK=01 for one cycle, MEM_AS high on the same edge, ERR=0.
- Contention: REQ=11 held, each access completing in 6 cycles → grant order 0,1,0,1. Strobe-high gaps between accesses are ≥8 cycles, and MEM_A alternates P0_A/P1_A.
- Timeout: REQ=10, MEM_VALID held high → on cycle 64 of ACCESS, ACK=10 and ERR=1 together, and strobes are released.
- Gap extension: MEM_VALID held low for 12 cycles after release → IDLE is re-entered only after MEM_VALID goes high (more than 8 cycles), and no early MEM_AS.
- Async reset: RST low while in ACCESS → MEM_AS/UDS/LDS=1 and OWN=0 immediately. After release, no ACK is issued for the aborted access.
